bpu_update_scheduler: RTL and testbench
=======================================

// Module: bpu_update_scheduler
// PURPOSE
//  Sequences the shared PHT/BHT tables of the direction predictor. After reset or a
//  clear request it sweeps every table index with one clear write per cycle. It buffers
//  resolved-branch updates from ID in a small FIFO. It arbitrates the single table port
//  between IF-stage lookups and queued updates, and keeps branch/mispredict statistics.
// PARAMETERS
//  PC_WIDTH      64   width of PC buses
//  HASH_WIDTH    8    table index width; TBL_SIZE = 2**HASH_WIDTH entries swept at init
//  FIFO_DEPTH    4    update queue entries (power of 2)
//  STARVE_LIMIT  8    cycles a queued head may lose to lookups before it is forced
// PORTS
//  clock          in   1           clock
//  reset          in   1           sync, active-high
//  upd_valid      in   1           resolved branch from ID
//  upd_ready      out  1           queue accepts this cycle
//  upd_pc         in   PC_WIDTH    branch PC
//  upd_taken      in   1           actual direction
//  upd_jumptype   in   2           0 = not a branch
//  upd_mispred    in   1           prediction was wrong
//  lk_req         in   1           IF lookup wants the table port
//  lk_gnt         out  1           lookup granted this cycle
//  clear_req      in   1           re-init tables, drop queue
//  init_busy      out  1           clear sweep in progress
//  tbl_clr        out  1           clear write strobe
//  tbl_clr_idx    out  HASH_WIDTH  index being cleared
//  tbl_upd        out  1           update write strobe (queue head)
//  tbl_upd_pc     out  PC_WIDTH    head PC
//  tbl_upd_taken  out  1           head direction
//  stat_branches  out  32          branches enqueued, saturating
//  stat_mispred   out  32          mispredicts enqueued, saturating
// BEHAVIOUR
//  - Reset: reset reset, synchronous, active-high; clock clock. State=INIT, idx=0,
//    count=0, starve=0, stats=0. All outputs are 0 while reset is high.
//  - FSM INIT: tbl_clr=1 and tbl_clr_idx=idx. idx increments every cycle. When
//    idx==TBL_SIZE-1, next state is RUN. init_busy=1; upd_ready=0; lk_gnt=0; tbl_upd=0.
//    The first clear cycle is the cycle after reset deasserts. The sweep is exactly
//    TBL_SIZE cycles.
//  - FSM RUN: tbl_clr=0; init_busy=0.
//  - clear_req (any state, sampled at posedge): next state=INIT, idx=0, count=0 (pending
//    entries dropped), starve=0. If asserted during INIT, the sweep restarts at 0.
//    Stats are kept.
//  - Enqueue: upd_ready = RUN & count<FIFO_DEPTH & !clear_req. There is no full-queue
//    pass-through: simultaneous pop does not raise upd_ready.
//    On upd_valid&upd_ready:
//      - If upd_jumptype!=0: push {pc,taken}; stat_branches+=1; stat_mispred+=upd_mispred.
//      - If upd_jumptype==0: consumed silently, no push, no stat change.
//    Both counters saturate at 32'hFFFF_FFFF.
//  - Latency: an entry pushed at edge N is at the head from cycle N+1. Earliest tbl_upd
//    is cycle N+1.
//  - Arbitration in RUN with count>0. Issue head (tbl_upd=1, pop at next edge) when any
//    of these holds:
//      - !lk_req
//      - count==FIFO_DEPTH
//      - starve==STARVE_LIMIT
//    Otherwise lk_gnt=1.
//  - lk_gnt = RUN & lk_req & !tbl_upd. The two outputs are mutually exclusive.
//  - tbl_upd_pc and tbl_upd_taken always reflect the head; valid only with tbl_upd.
//  - Starve counter: increments each cycle the head exists and loses to a lookup. It
//    clears on pop, on an empty queue, and on clear_req.
//  - Push and pop on the same edge: count unchanged, pointers both advance. Pointers
//    wrap modulo FIFO_DEPTH.
//  - Outputs are combinational from registered state plus lk_req/upd_valid. There is no
//    combinational path from lk_req to upd_ready.
// TESTING
//  1. Release reset
//     -> init_busy=1 and tbl_clr=1 for 256 cycles with tbl_clr_idx 0..255 in order.
//     -> Then init_busy=0, upd_ready=1, and lk_gnt tracks lk_req.
//  2. RUN, lk_req=0; push pc=0x8000_0010, taken=1, jumptype=1, mispred=1
//     -> Next cycle: tbl_upd=1, tbl_upd_pc=0x8000_0010, tbl_upd_taken=1.
//     -> stat_branches=1, stat_mispred=1.
//  3. lk_req held 1; push 4 branches back-to-back
//     -> After the 4th push, upd_ready=0 and lk_gnt=0 for exactly one cycle (head issued).
//     -> Then count=3 and lk_gnt=1.
//  4. lk_req held 1; single queued entry
//     -> lk_gnt=1 for 8 cycles, then tbl_upd=1 for one cycle (starve force).
//     -> Queue empty afterwards.
//  5. Push with jumptype=0 -> accepted, no tbl_upd, stats unchanged.
//  6. 3 entries pending; pulse clear_req
//     -> No tbl_upd issued for those entries.
//     -> 256-cycle sweep from idx 0; stats retain prior values.
//     -> clear_req mid-sweep at idx=100 restarts at idx 0.

Source files
------------

// File: rtl/bpu_update_scheduler.sv
// Table-port sequencer for the direction predictor: clear sweep after reset/clear,
// small update FIFO, lookup-vs-update arbitration with starvation guard, and statistics.
module bpu_update_scheduler #(
    parameter int PC_WIDTH     = 64,
    parameter int HASH_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_taken,
    input  logic [1:0]            upd_jumptype,
    input  logic                  upd_mispred,
    input  logic                  lk_req,
    output logic                  lk_gnt,
    input  logic                  clear_req,
    output logic                  init_busy,
    output logic                  tbl_clr,
    output logic [HASH_WIDTH-1:0] tbl_clr_idx,
    output logic                  tbl_upd,
    output logic [PC_WIDTH-1:0]   tbl_upd_pc,
    output logic                  tbl_upd_taken,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispred
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                state, state_next;
    logic [HASH_WIDTH-1:0] idx, idx_next;
    logic [CNT_W-1:0]      count, count_next;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [STV_W-1:0]      starve, starve_next;
    logic [31:0]           branches, mispreds;
    logic                  run;
    logic                  push;
    logic                  pop;

    logic [PC_WIDTH-1:0]   fifo_pc    [FIFO_DEPTH];
    logic                  fifo_taken [FIFO_DEPTH];

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        run           = 1'b0;
        init_busy     = 1'b0;
        tbl_clr       = 1'b0;
        tbl_clr_idx   = '0;
        upd_ready     = 1'b0;
        tbl_upd       = 1'b0;
        lk_gnt        = 1'b0;
        tbl_upd_pc    = '0;
        tbl_upd_taken = 1'b0;
        stat_branches = '0;
        stat_mispred  = '0;
        push          = 1'b0;
        pop           = 1'b0;
        state_next    = state;
        idx_next      = idx;
        count_next    = count;
        starve_next   = '0;

        if (!reset) begin
            run           = (state == ST_RUN);
            init_busy     = (state == ST_INIT);
            tbl_clr       = init_busy;
            tbl_clr_idx   = idx;
            upd_ready     = run && (count < FULL_COUNT) && !clear_req;
            // Head wins when lookups are idle, the queue is full, or it has waited too long.
            tbl_upd       = run && (count != '0) &&
                            (!lk_req || (count == FULL_COUNT) || (starve == STARVE_MAX));
            lk_gnt        = run && lk_req && !tbl_upd;
            tbl_upd_pc    = fifo_pc[rd_ptr];
            tbl_upd_taken = fifo_taken[rd_ptr];
            stat_branches = branches;
            stat_mispred  = mispreds;
            push          = upd_valid && upd_ready && (upd_jumptype != 2'd0);
            pop           = tbl_upd;
        end

        if (clear_req) begin
            state_next = ST_INIT;
            idx_next   = '0;
            count_next = '0;
        end else begin
            if (state == ST_INIT) begin
                idx_next = idx + HASH_WIDTH'(1);
                if (&idx) begin
                    state_next = ST_RUN;
                end
            end
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
            if ((count != '0) && lk_gnt) begin
                starve_next = starve + STV_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_INIT;
            idx      <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            starve   <= '0;
            branches <= '0;
            mispreds <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            count  <= count_next;
            starve <= starve_next;
            if (clear_req) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            if (push) begin
                if (branches != '1) begin
                    branches <= branches + 32'd1;
                end
                if (upd_mispred && (mispreds != '1)) begin
                    mispreds <= mispreds + 32'd1;
                end
            end
        end
    end

    // NOTE: queue storage has no reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= upd_pc;
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Bench for bpu_update_scheduler: directed vectors, multi-cycle corner sequences, and
// random traffic checked every cycle against a queue-based reference model.
module tb_bpu_update_scheduler;

    logic        clock;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_jumptype;
    logic        upd_mispred;
    logic        lk_req;
    logic        lk_gnt;
    logic        clear_req;
    logic        init_busy;
    logic        tbl_clr;
    logic [7:0]  tbl_clr_idx;
    logic        tbl_upd;
    logic [63:0] tbl_upd_pc;
    logic        tbl_upd_taken;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    bpu_update_scheduler dut (
        .clock         (clock),
        .reset         (reset),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_jumptype  (upd_jumptype),
        .upd_mispred   (upd_mispred),
        .lk_req        (lk_req),
        .lk_gnt        (lk_gnt),
        .clear_req     (clear_req),
        .init_busy     (init_busy),
        .tbl_clr       (tbl_clr),
        .tbl_clr_idx   (tbl_clr_idx),
        .tbl_upd       (tbl_upd),
        .tbl_upd_pc    (tbl_upd_pc),
        .tbl_upd_taken (tbl_upd_taken),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the queue is a plain SV queue, the sweep a counter of cleared entries.
    typedef struct packed {
        logic [63:0] pc;
        logic        taken;
    } ent_t;

    ent_t        q[$];
    bit          m_run;
    int          m_idx;
    int          m_starve;
    bit [31:0]   m_br;
    bit [31:0]   m_mp;
    bit          e_ready, e_upd, e_gnt;

    task automatic model_reset();
        q.delete();
        m_run    = 1'b0;
        m_idx    = 0;
        m_starve = 0;
        m_br     = '0;
        m_mp     = '0;
    endtask

    // Wait for the falling edge and compare every output with the model's view of this cycle.
    task automatic sample();
        logic [7:0] idx_exp;
        logic [7:0] idx_act;
        @(negedge clock);
        e_ready = m_run && (q.size() < 4) && !clear_req;
        e_upd   = m_run && (q.size() > 0) && (!lk_req || q.size() == 4 || m_starve == 8);
        e_gnt   = m_run && lk_req && !e_upd;
        idx_exp = m_run ? 8'd0 : 8'(m_idx);
        idx_act = m_run ? 8'd0 : tbl_clr_idx;
        check("model_ctrl", {init_busy, tbl_clr, idx_act, upd_ready, lk_gnt, tbl_upd},
              {!m_run, !m_run, idx_exp, e_ready, e_gnt, e_upd});
        if (e_upd) begin
            check("model_head", {tbl_upd_pc, tbl_upd_taken}, {q[0].pc, q[0].taken});
        end
        check("model_stats", {stat_branches, stat_mispred}, {m_br, m_mp});
    endtask

    // Take the rising edge and move the model forward with the inputs that were applied.
    task automatic advance();
        int pre_size;
        @(posedge clock);
        pre_size = q.size();
        if (clear_req) begin
            m_run    = 1'b0;
            m_idx    = 0;
            m_starve = 0;
            q.delete();
        end else begin
            if (e_upd) begin
                void'(q.pop_front());
            end
            if (upd_valid && e_ready && upd_jumptype != 2'd0) begin
                q.push_back(ent_t'{upd_pc, upd_taken});
                if (m_br != 32'hFFFF_FFFF) m_br++;
                if (upd_mispred && m_mp != 32'hFFFF_FFFF) m_mp++;
            end
            if (pre_size > 0 && e_gnt) m_starve++;
            else m_starve = 0;
            if (!m_run) begin
                if (m_idx == 255) begin
                    m_run = 1'b1;
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        upd_valid    = 1'b0;
        upd_pc       = '0;
        upd_taken    = 1'b0;
        upd_jumptype = 2'd0;
        upd_mispred  = 1'b0;
        clear_req    = 1'b0;
    endtask

    task automatic set_push(input logic [63:0] pc, input logic tk, input logic [1:0] jt,
                            input logic mp);
        upd_valid    = 1'b1;
        upd_pc       = pc;
        upd_taken    = tk;
        upd_jumptype = jt;
        upd_mispred  = mp;
    endtask

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        tk;
        logic [1:0]  jt;
        logic        mp;
        logic        lk;
        logic        e_ready;
        logic        e_gnt;
        logic        e_upd;
        logic [63:0] e_pc;
        logic        e_tk;
        logic [31:0] e_br;
        logic [31:0] e_mp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit [31:0] saved_br;
        bit [31:0] saved_mp;

        // Row order: v, pc, tk, jt, mp, lk | ready, gnt, upd, head pc, head taken, branches, mispred
        vecs[0]  = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 32'd0, 32'd0};
        vecs[2]  = '{1'b1, 64'h8000_0010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 32'd0, 32'd0};
        vecs[3]  = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h8000_0010, 1'b1, 32'd1, 32'd1};
        vecs[4]  = '{1'b1, 64'h1234,      1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 32'd1, 32'd1};
        vecs[5]  = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,         1'b0, 32'd1, 32'd1};
        vecs[6]  = '{1'b1, 64'h40,        1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 32'd1, 32'd1};
        vecs[7]  = '{1'b1, 64'h44,        1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 32'd2, 32'd1};
        vecs[8]  = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h40,        1'b0, 32'd3, 32'd2};
        vecs[9]  = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h44,        1'b1, 32'd3, 32'd2};
        vecs[10] = '{1'b0, 64'h0,         1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,         1'b0, 32'd3, 32'd2};

        // Reset: outputs held at zero even with requests asserted.
        idle_inputs();
        reset     = 1'b1;
        lk_req    = 1'b1;
        upd_valid = 1'b1;
        upd_jumptype = 2'd1;
        repeat (2) begin
            @(negedge clock);
            check("reset_outputs",
                  {init_busy, tbl_clr, tbl_clr_idx, upd_ready, lk_gnt, tbl_upd, stat_branches, stat_mispred},
                  '0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_inputs();
        model_reset();

        // Initial sweep: 256 cycles, indices in order, no port grants.
        for (int i = 0; i < 256; i++) begin
            lk_req = 1'($urandom_range(0, 1));
            sample();
            check("init_sweep", {init_busy, tbl_clr, tbl_clr_idx, tbl_upd, lk_gnt, upd_ready},
                  {1'b1, 1'b1, i[7:0], 1'b0, 1'b0, 1'b0});
            advance();
        end
        lk_req = 1'b1;
        sample();
        check("run_gnt_hi", {init_busy, upd_ready, lk_gnt}, 3'b011);
        advance();
        lk_req = 1'b0;
        sample();
        check("run_gnt_lo", {init_busy, upd_ready, lk_gnt}, 3'b010);
        advance();

        // Directed vector table.
        for (int r = 0; r < 11; r++) begin
            idle_inputs();
            if (vecs[r].v) set_push(vecs[r].pc, vecs[r].tk, vecs[r].jt, vecs[r].mp);
            lk_req = vecs[r].lk;
            sample();
            check("vec_ctrl", {upd_ready, lk_gnt, tbl_upd},
                  {vecs[r].e_ready, vecs[r].e_gnt, vecs[r].e_upd});
            check("vec_stats", {stat_branches, stat_mispred}, {vecs[r].e_br, vecs[r].e_mp});
            if (vecs[r].e_upd) begin
                check("vec_head", {tbl_upd_pc, tbl_upd_taken}, {vecs[r].e_pc, vecs[r].e_tk});
            end
            advance();
        end
        idle_inputs();

        // Full queue forces the head past a pending lookup.
        lk_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_push(64'h1000 + 64'(k * 4), 1'(k), 2'd1, 1'b0);
            step();
        end
        idle_inputs();
        sample();
        check("full_force", {upd_ready, lk_gnt, tbl_upd}, 3'b001);
        check("full_head_pc", tbl_upd_pc, 64'h1000);
        advance();
        sample();
        check("after_force", {upd_ready, lk_gnt, tbl_upd}, 3'b110);
        advance();
        lk_req = 1'b0;
        repeat (3) step();
        sample();
        check("drained", tbl_upd, 1'b0);
        advance();

        // Starvation limit: eight lookups win, then the head is forced once.
        lk_req = 1'b1;
        set_push(64'h2000, 1'b1, 2'd1, 1'b0);
        step();
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            sample();
            check("starve_lookup", {lk_gnt, tbl_upd}, 2'b10);
            advance();
        end
        sample();
        check("starve_force", {lk_gnt, tbl_upd, tbl_upd_pc}, {1'b0, 1'b1, 64'h2000});
        advance();
        sample();
        check("starve_empty", {lk_gnt, tbl_upd}, 2'b10);
        advance();

        // Clear with pending entries, then a restart in the middle of the sweep.
        for (int k = 0; k < 3; k++) begin
            set_push(64'h3000 + 64'(k * 4), 1'b1, 2'd2, 1'b1);
            step();
        end
        idle_inputs();
        saved_br  = m_br;
        saved_mp  = m_mp;
        clear_req = 1'b1;
        sample();
        check("clear_cycle", {upd_ready, tbl_upd}, 2'b00);
        advance();
        clear_req = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            if (i == 100) clear_req = 1'b1;
            sample();
            check("sweep_pre", {init_busy, tbl_clr_idx, tbl_upd}, {1'b1, i[7:0], 1'b0});
            advance();
        end
        clear_req = 1'b0;
        for (int i = 0; i < 256; i++) begin
            sample();
            check("sweep_restart", {init_busy, tbl_clr, tbl_clr_idx, tbl_upd},
                  {1'b1, 1'b1, i[7:0], 1'b0});
            if (i == 255) check("stats_kept", {stat_branches, stat_mispred}, {saved_br, saved_mp});
            advance();
        end
        lk_req = 1'b0;
        sample();
        check("post_clear_empty", {init_busy, tbl_upd, upd_ready}, 3'b001);
        advance();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            upd_valid    = 1'($urandom_range(0, 1));
            upd_pc       = {$urandom, $urandom};
            upd_taken    = 1'($urandom_range(0, 1));
            upd_jumptype = 2'($urandom_range(0, 3));
            upd_mispred  = 1'($urandom_range(0, 1));
            lk_req       = ($urandom_range(0, 3) != 0);
            clear_req    = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
